sync_fifo: RTL and testbench
============================

# sync_fifo

Parametrised single-clock FIFO that generalises the CPU's fixed 64-bit × 16 buffer. Width, depth and almost-full/almost-empty thresholds are parameters, and the block exposes a live fill count and sticky error flags that software can clear. Read mode is either registered (1-cycle latency) or first-word-fall-through (FWFT), chosen at compile time. It buffers traffic between pipeline stages and the supporting modules under `cpu/supported_modules`.

## Interface
- `DATA_WIDTH`, default 64: word width in bits.
- `DEPTH`, default 16: number of entries. Must be a power of two, ≥ 2.
- `AF_LEVEL`, default DEPTH-2: `almost_full` asserts when count ≥ AF_LEVEL.
- `AE_LEVEL`, default 2: `almost_empty` asserts when count ≤ AE_LEVEL.

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: write request.
- `wr_data` in DATA_WIDTH: write word.
- `rd_en` in 1: read request (pop).
- `rd_data` out DATA_WIDTH: read word.
- `rd_valid` out 1: `rd_data` is valid.
- `full` out 1: count == DEPTH.
- `empty` out 1: count == 0.
- `almost_full` out 1: threshold flag.
- `almost_empty` out 1: threshold flag.
- `count` out AW+1, where AW = $clog2(DEPTH): current occupancy.
- `overflow` out 1: sticky; write attempted while full.
- `underflow` out 1: sticky; read attempted while empty.
- `clr_err` in 1: clears `overflow` and `underflow`.

## Operation
- Pointers `wptr` and `rptr` are AW+1 bits; the MSB is the wrap bit. Storage is indexed by `ptr[AW-1:0]`.
- `count = wptr - rptr`, modulo 2^(AW+1).
- Flags:
  - `full` = MSBs differ and low bits equal.
  - `empty` = pointers equal.
- Write accepted (`we`) = `wr_en & ~full`. On `we`, store `wr_data` at `wptr` and increment `wptr`.
- Read accepted (`re`) = `rd_en & ~empty`. On `re`, increment `rptr`.
- Acceptance uses current-cycle flags only. A write to a full FIFO is rejected even if a read happens in the same cycle.
- When full or empty, a simultaneous read and write are handled independently:
  - Full: the read is accepted, the write is rejected and `overflow` sets.
  - Empty: the write is accepted, the read is rejected and `underflow` sets.
- Error flags:
  - `overflow` sets on `wr_en & full`.
  - `underflow` sets on `rd_en & empty`.
  - Both hold until `clr_err`. If set and clear occur in the same cycle, set wins.
- Reset values: pointers 0, `count`=0, `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0, `overflow`=0, `underflow`=0, `rd_valid`=0, `rd_data`=0.
- Storage contents are not reset.
- Reset asserted mid-operation discards all entries at that edge. `wr_en` and `rd_en` are ignored while `rst` is high.

## Timing
- All flags and `count` are combinational from registered pointers. They reflect accepted operations one cycle after the accepting edge.
- Registered mode:
  - A `re` at edge N loads `rd_data` from `mem[rptr]` at edge N, with `rd_valid`=1 for the following cycle.
  - `rd_valid` is a one-cycle pulse per accepted read.
  - `rd_data` holds its last value otherwise.
- FWFT mode: see Configuration.
- Write-to-read latency (empty FIFO): a write at edge N clears `empty` after N.
  - Registered mode: earliest `rd_data` is valid after edge N+1.
  - FWFT mode: head is valid after edge N.
- Throughput: one write and one read per cycle, sustained.

## Configuration
- Macro `SYNC_FIFO_FWFT_EN`.
- Defined:
  - `rd_data` = `mem[rptr]`, an asynchronous head read.
  - `rd_valid` = `~empty`.
  - `rd_en` acts as an acknowledge that pops the head.
  - No read register.
- Undefined: registered read, as described in Timing.
- Flags, count and error behaviour are identical in both modes.

## Structure
- `fifo_pkg` (shared header):
  - `clog2` helper function.
  - Pointer-width and count-width derivation constants.
  - Power-of-two depth check, which elaborates an error on a bad DEPTH.
- Sub-module `sync_fifo_ram`:
  - DATA_WIDTH × DEPTH array.
  - One synchronous write port.
  - One asynchronous read port.
  - `sync_fifo` registers the read output in registered mode.
- Top level contains pointers, flag logic, error registers and the read register.

## Test plan
- **Reset state**: DEPTH=16. Assert `rst` for 2 cycles → `empty`=1, `almost_empty`=1, `count`=0, all other outputs 0.
- **Fill to full**: 16 writes of 0..15 → `count`=16, `full`=1. `almost_full` rises once count reaches 14.
  - A 17th write sets `overflow`; `count` stays 16.
- **Drain in order**: 16 reads → `rd_data` 0..15 in order; `empty`=1 afterwards.
  - A 17th read sets `underflow`.
  - `clr_err` then clears both error flags.
- **Wrap-around**: write 10, read 10, write 16, read 16 → data stays in order across the pointer MSB wrap; `full` asserts at count 16.
- **Simultaneous read/write**:
  - At count 5: 20 cycles of both → `count` stays 5; data out matches data in, delayed by 5 entries.
  - At empty: simultaneous read and write → write accepted, `underflow`=1, `count`=1.
- **Mid-stream reset and FWFT**:
  - Reset at count 7 → `count`=0 the next cycle.
  - With `SYNC_FIFO_FWFT_EN` defined, write 0xA5 → `rd_valid`=1 and `rd_data`=0xA5 in the cycle after the write, with no `rd_en` needed.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers for the parametrised synchronous FIFO.
//   clog2()       - ceiling log2 used to size pointers and storage addresses
//   ptr_width()   - pointer width: address bits plus one wrap bit
//   count_width() - occupancy width, wide enough to hold DEPTH itself
//   is_pow2()     - depth legality check, evaluated at elaboration
package fifo_pkg;

    localparam int unsigned FIFO_DEFAULT_WIDTH = 64;
    localparam int unsigned FIFO_DEFAULT_DEPTH = 16;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return clog2(depth) + 1;
    endfunction

    function automatic int unsigned count_width(input int unsigned depth);
        return clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int unsigned v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: DATA_WIDTH x DEPTH storage for sync_fifo.
// One synchronous write port, one asynchronous read port. Contents are
// never reset.
//   clk   - clock
//   we    - write enable
//   waddr - write address
//   wdata - write word
//   raddr - read address
//   rdata - combinational read word at raddr
module sync_fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FIFO_DEFAULT_WIDTH,
    parameter int unsigned DEPTH      = FIFO_DEFAULT_DEPTH
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [clog2(DEPTH)-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0]       wdata,
    input  logic [clog2(DEPTH)-1:0]     raddr,
    output logic [DATA_WIDTH-1:0]       rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: parametrised single-clock FIFO with fill count, threshold
// flags and sticky, software-clearable error flags.
// Compile-time option: define SYNC_FIFO_FWFT_EN for first-word-fall-through
// reads (rd_data shows the head, rd_valid = ~empty, rd_en pops). Without it
// reads are registered: one cycle latency, rd_valid pulses per accepted read.
//   clk, rst       - clock, synchronous active-high reset
//   wr_en, wr_data - write request and word
//   rd_en          - read request / pop
//   rd_data        - read word, rd_valid marks it valid
//   full, empty    - occupancy == DEPTH / == 0
//   almost_full    - count >= AF_LEVEL
//   almost_empty   - count <= AE_LEVEL
//   count          - current occupancy
//   overflow       - sticky: write attempted while full
//   underflow      - sticky: read attempted while empty
//   clr_err        - clears overflow/underflow (a same-cycle set wins)
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FIFO_DEFAULT_WIDTH,
    parameter int unsigned DEPTH      = FIFO_DEFAULT_DEPTH,
    parameter int unsigned AF_LEVEL   = DEPTH - 2,
    parameter int unsigned AE_LEVEL   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          rd_en,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          rd_valid,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          overflow,
    output logic                          underflow,
    input  logic                          clr_err
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned PW = ptr_width(DEPTH);

    typedef logic [PW-1:0] ptr_t;

    localparam ptr_t PTR_ONE = ptr_t'(1);
    localparam ptr_t AF_THR  = ptr_t'(AF_LEVEL);
    localparam ptr_t AE_THR  = ptr_t'(AE_LEVEL);

    if (!is_pow2(DEPTH)) begin : g_depth_check
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    ptr_t                  wptr;
    ptr_t                  rptr;
    logic                  we;
    logic                  re;
    logic [DATA_WIDTH-1:0] head;

    // Wrap bit differs with equal address bits means DEPTH entries apart.
    always_comb begin
        full         = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
        empty        = (wptr == rptr);
        count        = wptr - rptr;
        almost_full  = (count >= AF_THR);
        almost_empty = (count <= AE_THR);
        we           = wr_en && !full;
        re           = rd_en && !empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (we) begin
                wptr <= wptr + PTR_ONE;
            end
            if (re) begin
                rptr <= rptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (wr_en && full)  || (overflow  && !clr_err);
            underflow <= (rd_en && empty) || (underflow && !clr_err);
        end
    end

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (we && !rst),
        .waddr (wptr[AW-1:0]),
        .wdata (wr_data),
        .raddr (rptr[AW-1:0]),
        .rdata (head)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign rd_data  = head;
    assign rd_valid = !empty;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= re;
            if (re) begin
                rd_data <= head;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: randomized and directed checks of sync_fifo (DEPTH=16)
// against a queue-based model of the FIFO's observable behaviour.
module tb_sync_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full, empty, almost_full, almost_empty;
    logic [4:0]    count;
    logic          overflow, underflow;

    int n_cmp  = 0;
    int n_fail = 0;

    sync_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_LEVEL   (AF),
        .AE_LEVEL   (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: contents as a queue, flags derived from its size.
    logic [DW-1:0] q[$];
    bit            m_init = 0;
    bit            m_ovf = 0, m_udf = 0, m_rv = 0;
    logic [DW-1:0] m_rd = '0;

    always @(posedge clk) begin
        bit was_full, was_empty;
        if (rst) begin
            q.delete();
            m_ovf  = 0;
            m_udf  = 0;
            m_rv   = 0;
            m_rd   = '0;
            m_init = 1;
        end else begin
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            m_rv = 0;
            if (rd_en && !was_empty) begin
                m_rd = q.pop_front();
                m_rv = 1;
            end
            if (wr_en && !was_full) q.push_back(wr_data);
            if (wr_en && was_full) m_ovf = 1;
            else if (clr_err)      m_ovf = 0;
            if (rd_en && was_empty) m_udf = 1;
            else if (clr_err)       m_udf = 0;
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("count", count, 64'(q.size()));
            chk("full", full, 64'(q.size() == DEPTH));
            chk("empty", empty, 64'(q.size() == 0));
            chk("almost_full", almost_full, 64'(q.size() >= AF));
            chk("almost_empty", almost_empty, 64'(q.size() <= AE));
            chk("overflow", overflow, 64'(m_ovf));
            chk("underflow", underflow, 64'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
            chk("rd_valid", rd_valid, 64'(q.size() != 0));
            if (q.size() != 0) chk("rd_data", rd_data, 64'(q[0]));
`else
            chk("rd_valid", rd_valid, 64'(m_rv));
            chk("rd_data", rd_data, 64'(m_rd));
`endif
        end
    end

    // Inputs change on the falling edge; one call spans one rising edge.
    task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        clr_err = c;
        @(negedge clk);
    endtask

    logic [DW-1:0] sv[25];

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_empty", empty, 1);
        chk("rst_almost_empty", almost_empty, 1);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_almost_full", almost_full, 0);
        chk("rst_errs", {overflow, underflow}, 0);
`ifndef SYNC_FIFO_FWFT_EN
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            step(1, DW'(i), 0, 0);
            chk("fill_almost_full", almost_full, 64'(i + 1 >= 14));
        end
        chk("fill_count", count, 16);
        chk("fill_full", full, 1);
        step(1, 32'hDEAD, 0, 0);
        chk("ovf_set", overflow, 1);
        chk("ovf_count", count, 16);

        for (int i = 0; i < 16; i++) begin
            step(0, '0, 1, 0);
`ifndef SYNC_FIFO_FWFT_EN
            chk("drain_valid", rd_valid, 1);
            chk("drain_data", rd_data, 64'(i));
`endif
        end
        chk("drain_empty", empty, 1);
        step(0, '0, 1, 0);
        chk("udf_set", underflow, 1);
        step(0, '0, 0, 1);
        chk("clr_errs", {overflow, underflow}, 0);

        for (int i = 0; i < 10; i++) step(1, DW'(100 + i), 0, 0);
        for (int i = 0; i < 10; i++) step(0, '0, 1, 0);
        for (int i = 0; i < 16; i++) step(1, DW'(200 + i), 0, 0);
        chk("wrap_full", full, 1);
        chk("wrap_count", count, 16);
        for (int i = 0; i < 16; i++) begin
            step(0, '0, 1, 0);
`ifndef SYNC_FIFO_FWFT_EN
            chk("wrap_data", rd_data, 64'(200 + i));
`endif
        end

        for (int i = 0; i < 25; i++) sv[i] = $urandom;
        for (int i = 0; i < 5; i++) step(1, sv[i], 0, 0);
        for (int k = 0; k < 20; k++) begin
            step(1, sv[5 + k], 1, 0);
            chk("simul_count", count, 5);
`ifndef SYNC_FIFO_FWFT_EN
            chk("simul_data", rd_data, 64'(sv[k]));
`endif
        end
        for (int i = 0; i < 5; i++) step(0, '0, 1, 0);
        step(1, 32'h77, 1, 0);
        chk("empty_rw_underflow", underflow, 1);
        chk("empty_rw_count", count, 1);
        step(0, '0, 0, 1);

        for (int i = 0; i < 6; i++) step(1, DW'(300 + i), 0, 0);
        chk("pre_reset_count", count, 7);
        rst = 1'b1;
        step(1, '0, 1, 0);
        rst = 1'b0;
        chk("mid_reset_count", count, 0);
        chk("mid_reset_empty", empty, 1);
        step(0, '0, 0, 0);

`ifdef SYNC_FIFO_FWFT_EN
        step(1, 32'hA5, 0, 0);
        chk("fwft_valid", rd_valid, 1);
        chk("fwft_data", rd_data, 64'hA5);
        step(0, '0, 1, 0);
`endif

        for (int n = 0; n < 3000; n++) begin
            bit w, r;
            int bias;
            bias = ((n / 300) % 2 == 0) ? 70 : 30;
            w = ($urandom_range(99) < bias);
            r = ($urandom_range(99) < 100 - bias);
            rst = ($urandom_range(255) == 0);
            step(w, $urandom, r, ($urandom_range(15) == 0));
        end
        rst = 1'b0;
        step(0, '0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: run did not finish, expected completion before 1ms");
        $fatal(1);
    end

endmodule
